// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive-side ASCII word parser.
package uart_pkg;

    localparam int WORD_W          = 16;
    localparam int NUM_INPUT_WORDS = 512;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;

    typedef enum logic [1:0] {
        IDLE,
        SIGN,
        DIGITS,
        SKIP
    } parse_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/ascii_dec_acc.sv
// Decimal digit accumulator: builds an unsigned magnitude one digit at a time
// and raises a sticky overflow once the value or digit count leaves range.
module ascii_dec_acc
    import uart_pkg::*;
#(
    parameter int WIDTH      = WORD_W,
    parameter int MAX_DIGITS = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic             neg_i,
    input  logic [3:0]       digit_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             ovf_o
);

    localparam int ACC_W = WIDTH + 2;
    localparam int PRD_W = ACC_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 2);

    localparam logic [PRD_W-1:0] LIM_POS = PRD_W'((1 << (WIDTH - 1)) - 1);
    localparam logic [PRD_W-1:0] LIM_NEG = PRD_W'(1 << (WIDTH - 1));
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_DIGITS + 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             ovf_q, ovf_d, ovf_base;
    logic [PRD_W-1:0] base, prod;

    // clear and step together load the first digit of a new line
    always_comb begin
        base     = clear_i ? '0 : PRD_W'(acc_q);
        cnt_base = clear_i ? '0 : cnt_q;
        ovf_base = clear_i ? 1'b0 : ovf_q;
        prod     = (base << 3) + (base << 1) + PRD_W'(digit_i);
        acc_d    = base[ACC_W-1:0];
        cnt_d    = cnt_base;
        ovf_d    = ovf_base;
        if (step_i) begin
            if (cnt_base != CNT_SAT) cnt_d = cnt_base + CNT_W'(1);
            if (!ovf_base) acc_d = prod[ACC_W-1:0];
            if ((prod > (neg_i ? LIM_NEG : LIM_POS)) || (cnt_d > CNT_MAX)) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // only in-range values are ever emitted, and those fit in WIDTH bits
    assign mag_o = acc_q[WIDTH-1:0];
    assign ovf_o = ovf_q;

endmodule

// File: rtl/uart_ascii_word_parser.sv
// Parses CR-terminated signed decimal lines into words for the sample memory.
// Define PARSER_SATURATE_EN to clamp overflowing lines instead of dropping them.
module uart_ascii_word_parser
    import uart_pkg::*;
#(
    parameter int WIDTH      = WORD_W,
    parameter int NUM_WORDS  = NUM_INPUT_WORDS,
    parameter int ADDR_W     = 9,
    parameter int MAX_DIGITS = 6
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              frame_clear,
    output logic              word_we,
    output logic [ADDR_W-1:0] word_addr,
    output logic [WIDTH-1:0]  word_data,
    output logic              frame_done,
    output logic              err_char,
    output logic              err_ovf
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    parse_state_e      state_q, state_d;
    logic              neg_q, neg_d;
    logic [ADDR_W-1:0] addr_q;
    logic              frame_done_q;
    logic              word_we_q;
    logic [WIDTH-1:0]  word_data_q, word_data_d;
    logic              err_char_q;
    logic              acc_clr, acc_step, emit, char_err;
    logic              take, is_dig, is_cr;
    logic [WIDTH-1:0]  mag;
    logic              acc_ovf;
`ifndef PARSER_SATURATE_EN
    logic              ovf_pulse;
    logic              err_ovf_q;
`endif

    ascii_dec_acc #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc (
        .clk_i   (sysclk),
        .rst_i   (rst),
        .clear_i (acc_clr),
        .step_i  (acc_step),
        .neg_i   (neg_d),
        .digit_i (rx_data[3:0]),
        .mag_o   (mag),
        .ovf_o   (acc_ovf)
    );

    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        acc_clr     = 1'b0;
        acc_step    = 1'b0;
        emit        = 1'b0;
        char_err    = 1'b0;
`ifndef PARSER_SATURATE_EN
        ovf_pulse   = 1'b0;
`endif
        word_data_d = neg_q ? -mag : mag;
`ifdef PARSER_SATURATE_EN
        if (acc_ovf) word_data_d = neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        // LF is transparent; a finished frame swallows everything until cleared
        take   = rx_valid && !frame_done_q && (rx_data != ASCII_LF);
        is_dig = is_digit(rx_data);
        is_cr  = (rx_data == ASCII_CR);

        if (frame_clear) begin
            state_d = IDLE;
            neg_d   = 1'b0;
            acc_clr = 1'b1;
        end else if (take) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == ASCII_MINUS) begin
                        state_d = SIGN;
                        neg_d   = 1'b1;
                        acc_clr = 1'b1;
                    end else if (is_dig) begin
                        state_d  = DIGITS;
                        neg_d    = 1'b0;
                        acc_clr  = 1'b1;
                        acc_step = 1'b1;
                    end else if (!is_cr) begin
                        state_d  = SKIP;
                        char_err = 1'b1;
                    end
                end
                SIGN: begin
                    if (is_dig) begin
                        state_d  = DIGITS;
                        acc_step = 1'b1;
                    end else begin
                        state_d  = is_cr ? IDLE : SKIP;
                        char_err = 1'b1;
                    end
                end
                DIGITS: begin
                    if (is_dig) begin
                        acc_step = 1'b1;
                    end else if (is_cr) begin
                        state_d = IDLE;
`ifdef PARSER_SATURATE_EN
                        emit = 1'b1;
`else
                        if (acc_ovf) ovf_pulse = 1'b1;
                        else         emit      = 1'b1;
`endif
                    end else begin
                        state_d  = SKIP;
                        char_err = 1'b1;
                    end
                end
                SKIP: begin
                    if (is_cr) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= IDLE;
            neg_q        <= 1'b0;
            addr_q       <= '0;
            frame_done_q <= 1'b0;
            word_we_q    <= 1'b0;
            word_data_q  <= '0;
            err_char_q   <= 1'b0;
`ifndef PARSER_SATURATE_EN
            err_ovf_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            neg_q      <= neg_d;
            word_we_q  <= emit;
            err_char_q <= char_err;
`ifndef PARSER_SATURATE_EN
            err_ovf_q  <= ovf_pulse;
`endif
            if (emit) word_data_q <= word_data_d;
            // address advances in the cycle after the write strobe it labelled
            if (frame_clear) begin
                addr_q       <= '0;
                frame_done_q <= 1'b0;
            end else begin
                if (emit && (addr_q == LAST_ADDR)) frame_done_q <= 1'b1;
                if (word_we_q) addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            end
        end
    end

    assign word_we    = word_we_q;
    assign word_addr  = addr_q;
    assign word_data  = word_data_q;
    assign frame_done = frame_done_q;
    assign err_char   = err_char_q;
`ifdef PARSER_SATURATE_EN
    assign err_ovf    = 1'b0;
`else
    assign err_ovf    = err_ovf_q;
`endif

endmodule

// File: tb/tb_uart_ascii_word_parser.sv
// Randomized and directed bench for uart_ascii_word_parser against a line-level model.
module tb_uart_ascii_word_parser;

    logic        sysclk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        frame_clear;
    logic        word_we;
    logic [8:0]  word_addr;
    logic [15:0] word_data;
    logic        frame_done;
    logic        err_char;
    logic        err_ovf;

    int n_run  = 0;
    int n_fail = 0;

    // {frame_done, addr, data} per write
    logic [25:0] obs_q[$];
    logic [25:0] exp_q[$];
    int obs_err, obs_ovf, exp_err, exp_ovf;
    int m_addr;
    bit m_done;

    uart_ascii_word_parser dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .frame_clear (frame_clear),
        .word_we     (word_we),
        .word_addr   (word_addr),
        .word_data   (word_data),
        .frame_done  (frame_done),
        .err_char    (err_char),
        .err_ovf     (err_ovf)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (rst) begin
            obs_q.delete();
            obs_err <= 0;
            obs_ovf <= 0;
        end else begin
            if (word_we) obs_q.push_back({frame_done, word_addr, word_data});
            if (err_char) obs_err <= obs_err + 1;
            if (err_ovf) obs_ovf <= obs_ovf + 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge sysclk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Line-level reference: what one CR-terminated line should do
    task automatic model_line(input string s);
        logic [7:0] q[$];
        logic [7:0] ch;
        bit neg, bad;
        int k0, nd;
        longint mag;
        logic [15:0] v;
        for (int k = 0; k < s.len(); k++) begin
            ch = s[k];
            if (ch != 8'h0A) q.push_back(ch);
        end
        if (m_done || q.size() == 0) return;
        neg = (q[0] == 8'h2D);
        k0  = neg ? 1 : 0;
        bad = (q.size() == k0);
        mag = 0;
        for (int k = k0; k < q.size(); k++) begin
            if (q[k] < 8'h30 || q[k] > 8'h39) bad = 1;
            else if (mag < 1000000) mag = mag * 10 + longint'(q[k] - 8'h30);
        end
        if (bad) begin
            exp_err++;
            return;
        end
        nd = q.size() - k0;
        if (nd > 6 || mag > (neg ? 32768 : 32767)) begin
`ifdef PARSER_SATURATE_EN
            mag = neg ? 32768 : 32767;
`else
            exp_ovf++;
            return;
`endif
        end
        v = 16'(neg ? -mag : mag);
        exp_q.push_back({(m_addr == 511), 9'(m_addr), v});
        if (m_addr == 511) begin
            m_done = 1;
            m_addr = 0;
        end else begin
            m_addr++;
        end
    endtask

    task automatic send_line(input string s, input int gap);
        for (int k = 0; k < s.len(); k++) begin
            send_byte(s[k]);
            if (gap > 0) idle($urandom_range(0, gap));
        end
        send_byte(8'h0D);
        model_line(s);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        rx_valid    = 1'b0;
        frame_clear = 1'b0;
        idle(2);
        rst     = 1'b0;
        exp_q.delete();
        exp_err = 0;
        exp_ovf = 0;
        m_addr  = 0;
        m_done  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_run += 6;
        if (word_we !== 1'b0)    begin n_fail++; $display("FAIL reset_word_we: got %b expected 0", word_we); end
        if (word_addr !== 9'd0)  begin n_fail++; $display("FAIL reset_word_addr: got %0d expected 0", word_addr); end
        if (word_data !== 16'd0) begin n_fail++; $display("FAIL reset_word_data: got %h expected 0", word_data); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        if (err_char !== 1'b0)   begin n_fail++; $display("FAIL reset_err_char: got %b expected 0", err_char); end
        if (err_ovf !== 1'b0)    begin n_fail++; $display("FAIL reset_err_ovf: got %b expected 0", err_ovf); end
        send_line("7", 0);
        rst = 1'b1;
        idle(1);
        n_run += 3;
        if (word_we !== 1'b0)    begin n_fail++; $display("FAIL reset_mid_we: got %b expected 0", word_we); end
        if (word_addr !== 9'd0)  begin n_fail++; $display("FAIL reset_mid_addr: got %0d expected 0", word_addr); end
        if (word_data !== 16'd0) begin n_fail++; $display("FAIL reset_mid_data: got %h expected 0", word_data); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        send_line("123", 0);
        n_run += 3;
        if (word_we !== 1'b1)        begin n_fail++; $display("FAIL basic_we0: got %b expected 1", word_we); end
        if (word_addr !== 9'd0)      begin n_fail++; $display("FAIL basic_addr0: got %0d expected 0", word_addr); end
        if (word_data !== 16'h007B)  begin n_fail++; $display("FAIL basic_data0: got %h expected 007b", word_data); end
        idle(1);
        n_run += 2;
        if (word_we !== 1'b0)        begin n_fail++; $display("FAIL basic_we_drop: got %b expected 0", word_we); end
        if (word_addr !== 9'd1)      begin n_fail++; $display("FAIL basic_addr_inc: got %0d expected 1", word_addr); end
        send_line("-45", 1);
        n_run += 3;
        if (word_we !== 1'b1)        begin n_fail++; $display("FAIL basic_we1: got %b expected 1", word_we); end
        if (word_addr !== 9'd1)      begin n_fail++; $display("FAIL basic_addr1: got %0d expected 1", word_addr); end
        if (word_data !== 16'hFFD3)  begin n_fail++; $display("FAIL basic_data1: got %h expected ffd3", word_data); end
    endtask

    task automatic test_errors();
        do_reset();
        send_line("", 0);
        send_line("-", 1);
        send_line("1a2", 0);
        send_line("\n", 0);
        send_line("x-9", 1);
        send_line("7", 0);
        idle(4);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL errors_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_run++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL errors_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_run += 2;
        if (obs_err != exp_err) begin n_fail++; $display("FAIL errors_err_char: got %0d expected %0d", obs_err, exp_err); end
        if (obs_ovf != exp_ovf) begin n_fail++; $display("FAIL errors_err_ovf: got %0d expected %0d", obs_ovf, exp_ovf); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_line("40000", 0);
        send_line("-32768", 0);
        send_line("32767", 1);
        send_line("-32769", 0);
        send_line("0000001", 0);
        send_line("000032767", 0);
        send_line("-0", 0);
        send_line("000123", 0);
        idle(4);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_run++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_run += 2;
        if (obs_err != exp_err) begin n_fail++; $display("FAIL ovf_err_char: got %0d expected %0d", obs_err, exp_err); end
        if (obs_ovf != exp_ovf) begin n_fail++; $display("FAIL ovf_err_ovf: got %0d expected %0d", obs_ovf, exp_ovf); end
    endtask

    task automatic test_frame();
        do_reset();
        for (int n = 0; n < 512; n++) send_line("1", 0);
        idle(2);
        n_run++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_set: got %b expected 1", frame_done); end
        send_line("1", 0);
        send_line("x", 0);
        idle(2);
        frame_clear = 1'b1;
        idle(1);
        frame_clear = 1'b0;
        m_addr = 0;
        m_done = 0;
        n_run++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_clear: got %b expected 0", frame_done); end
        send_byte("5");
        rx_valid    = 1'b1;
        rx_data     = "6";
        frame_clear = 1'b1;
        idle(1);
        rx_valid    = 1'b0;
        frame_clear = 1'b0;
        send_line("7", 0);
        idle(4);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL frame_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_run++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_run += 2;
        if (obs_err != exp_err) begin n_fail++; $display("FAIL frame_err_char: got %0d expected %0d", obs_err, exp_err); end
        if (obs_ovf != exp_ovf) begin n_fail++; $display("FAIL frame_err_ovf: got %0d expected %0d", obs_ovf, exp_ovf); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        send_byte("1");
        send_byte("2");
        do_reset();
        send_line("5", 0);
        idle(4);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_run++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte("9");
        send_byte(8'h0D);
        n_run += 3;
        if (word_we !== 1'b1)       begin n_fail++; $display("FAIL b2b_we0: got %b expected 1", word_we); end
        if (word_addr !== 9'd0)     begin n_fail++; $display("FAIL b2b_addr0: got %0d expected 0", word_addr); end
        if (word_data !== 16'd9)    begin n_fail++; $display("FAIL b2b_data0: got %h expected 0009", word_data); end
        send_byte("8");
        n_run += 2;
        if (word_we !== 1'b0)       begin n_fail++; $display("FAIL b2b_we_gap: got %b expected 0", word_we); end
        if (word_addr !== 9'd1)     begin n_fail++; $display("FAIL b2b_addr_inc: got %0d expected 1", word_addr); end
        send_byte(8'h0D);
        n_run += 3;
        if (word_we !== 1'b1)       begin n_fail++; $display("FAIL b2b_we1: got %b expected 1", word_we); end
        if (word_addr !== 9'd1)     begin n_fail++; $display("FAIL b2b_addr1: got %0d expected 1", word_addr); end
        if (word_data !== 16'd8)    begin n_fail++; $display("FAIL b2b_data1: got %h expected 0008", word_data); end
        model_line("9");
        model_line("8");
        idle(3);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        string s;
        int len, r;
        logic [7:0] ch;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            s   = "";
            len = $urandom_range(0, 8);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 19);
                if (r < 12)       ch = 8'h30 + 8'(r % 10);
                else if (r < 14)  ch = 8'h2D;
                else if (r == 14) ch = 8'h0A;
                else if (r == 15) ch = 8'h61;
                else              ch = 8'h30 + 8'($urandom_range(0, 9));
                s = $sformatf("%s%c", s, ch);
            end
            send_line(s, (n % 3 == 0) ? 0 : 2);
        end
        idle(4);
        n_run++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_run++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_run += 2;
        if (obs_err != exp_err) begin n_fail++; $display("FAIL random_err_char: got %0d expected %0d", obs_err, exp_err); end
        if (obs_ovf != exp_ovf) begin n_fail++; $display("FAIL random_err_ovf: got %0d expected %0d", obs_ovf, exp_ovf); end
    endtask

    initial begin
        rst         = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        frame_clear = 1'b0;
        test_reset();
        test_basic();
        test_errors();
        test_overflow();
        test_frame();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
